// File: rtl/result_fb_writer.sv
// result_fb_writer
// ----------------
// Captures one processed grayscale frame from the NPU result stream and writes
// it into the result region of the framebuffer. The region starts at word
// IMG2_START. When the whole frame has been written, the display select
// `enter` switches to the result image. The switch happens only during
// vertical blanking, so a torn image is never shown.
//
// Ports:
//   clk_25      in   1   pixel/system clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   single-cycle request to capture a new frame
//   in_valid    in   1   stream beat valid
//   in_data     in   8   grayscale pixel
//   in_last     in   1   marks the final beat of a frame (checked, not used to end it)
//   in_ready    out  1   writer accepts a beat this cycle
//   vs          in  10   vertical counter from the VGA timing generator
//   wr_en       out  1   framebuffer write strobe
//   wr_address  out 19   framebuffer word address
//   wr_data     out  8   framebuffer write data
//   enter       out  1   display select: 0 = original image, 1 = result image
//   busy        out  1   capture in progress or waiting for blanking
//   done        out  1   one-cycle pulse when the result becomes displayed
//   error       out  1   sticky in_last framing error
module result_fb_writer #(
    parameter int IMG_PIXELS   = 160000,
    parameter int IMG2_START   = 160000,
    parameter int VBLANK_START = 440
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [9:0]  vs,
    output logic        wr_en,
    output logic [18:0] wr_address,
    output logic [7:0]  wr_data,
    output logic        enter,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [18:0] BASE_ADDR = 19'(IMG2_START);
    localparam logic [17:0] LAST_IDX  = 18'(IMG_PIXELS - 1);
    localparam logic [9:0]  VBLANK_VS = 10'(VBLANK_START);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        WAIT_VBLANK = 2'd2,
        SHOW        = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [17:0] r_count;
    logic        r_wr_en;
    logic [18:0] r_wr_address;
    logic [7:0]  r_wr_data;
    logic        r_enter;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_last_beat;
    logic        w_in_vblank;

    assign w_accept    = in_valid && (r_state == RUN);
    assign w_last_beat = (r_count == LAST_IDX);
    assign w_in_vblank = (vs >= VBLANK_VS);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, SHOW: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // The frame ends on the pixel count alone; in_last is only checked.
                if (w_accept && w_last_beat) begin
                    w_state_next = WAIT_VBLANK;
                end
            end
            WAIT_VBLANK: begin
                if (w_in_vblank) begin
                    w_state_next = SHOW;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_enter      <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE, SHOW: begin
                    if (start) begin
                        r_count <= '0;
                        // Hide the region before it is overwritten.
                        r_enter <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_wr_en      <= 1'b1;
                        r_wr_address <= BASE_ADDR + {1'b0, r_count};
                        r_wr_data    <= in_data;
                        r_count      <= r_count + 18'd1;
                        // Flag in_last placed early, and in_last missing on the final beat.
                        if (in_last != w_last_beat) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                WAIT_VBLANK: begin
                    if (w_in_vblank) begin
                        r_enter <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == RUN);
    assign busy       = (r_state == RUN) || (r_state == WAIT_VBLANK);
    assign wr_en      = r_wr_en;
    assign wr_address = r_wr_address;
    assign wr_data    = r_wr_data;
    assign enter      = r_enter;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_result_fb_writer.sv
// Directed testbench for result_fb_writer with a reduced 16-pixel frame.
module tb_result_fb_writer;

    localparam int NPIX = 16;
    localparam int BASE = 160000;

    logic        clk_25;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [9:0]  vs;
    logic        wr_en;
    logic [18:0] wr_address;
    logic [7:0]  wr_data;
    logic        enter;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    result_fb_writer #(
        .IMG_PIXELS   (NPIX),
        .IMG2_START   (BASE),
        .VBLANK_START (440)
    ) dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .vs         (vs),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .enter      (enter),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    // Pulse start, then stream NPIX beats.
    // gap=1 alternates in_valid 1/0. last_idx is the beat carrying in_last.
    // vs_frame is driven during capture. Set stop_after below NPIX to abandon
    // the frame early and skip the end-of-frame checks.
    task automatic run_frame(input string name, input bit gap, input int last_idx,
                             input logic [9:0] vs_frame, input bit exp_err, input int stop_after);
        int beat;
        int cyc;
        bit v;
        vs    = vs_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, ".ready_after_start"}, in_ready, 1);
        chk({name, ".enter_cleared"}, enter, 0);
        chk({name, ".error_cleared"}, error, 0);
        beat = 0;
        cyc  = 0;
        while (beat < stop_after && cyc < 200) begin
            v        = gap ? ((cyc % 2) == 0) : 1'b1;
            in_valid = v;
            in_data  = 8'(beat);
            in_last  = (beat == last_idx);
            tick();
            if (v) begin
                chk({name, ".wr_en"}, wr_en, 1);
                chk({name, ".addr"}, wr_address, 32'(BASE + beat));
                chk({name, ".data"}, wr_data, 32'(beat));
                beat++;
            end else begin
                chk({name, ".no_write_on_gap"}, wr_en, 0);
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (beat < stop_after) begin
            chk({name, ".timeout"}, 32'(beat), 32'(stop_after));
        end
        if (stop_after == NPIX) begin
            chk({name, ".ready_low_after_final"}, in_ready, 0);
            chk({name, ".busy_waiting"}, busy, 1);
            chk({name, ".error"}, error, 32'(exp_err));
            chk({name, ".enter_not_yet"}, enter, 0);
        end
        $display("frame %s: %0d beats in %0d cycles", name, beat, cyc);
    endtask

    // Wait for the display swap once the frame is complete.
    // If vs is already in blanking, the swap lands on the next edge.
    task automatic expect_swap(input string name, input bit early_vblank);
        if (!early_vblank) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk({name, ".hold_enter"}, enter, 0);
                chk({name, ".hold_done"}, done, 0);
            end
            vs = 10'd440;
        end
        tick();
        chk({name, ".swap_enter"}, enter, 1);
        chk({name, ".swap_done"}, done, 1);
        chk({name, ".busy_off"}, busy, 0);
        tick();
        chk({name, ".done_pulse_end"}, done, 0);
        chk({name, ".enter_held"}, enter, 1);
        $display("swap %s: enter=%0d", name, enter);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        vs       = 10'd0;

        // Reset with random inputs applied
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_25);
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            vs       = 10'($urandom_range(0, 524));
        end
        #1;
        chk("rst.wr_en", wr_en, 0);
        chk("rst.wr_address", wr_address, 0);
        chk("rst.wr_data", wr_data, 0);
        chk("rst.enter", enter, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 0);
        @(negedge clk_25);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("post_rst.in_ready", in_ready, 0);
        chk("post_rst.busy", busy, 0);
        $display("reset: checks so far %0d", n_checks);

        // Full frame, continuous, final beat at vs=100 -> swap waits for vs=440
        run_frame("full", 1'b0, NPIX - 1, 10'd100, 1'b0, NPIX);
        expect_swap("full", 1'b0);

        // Alternating valid from SHOW, final beat at vs=450 -> swap next cycle
        run_frame("gaps", 1'b1, NPIX - 1, 10'd450, 1'b0, NPIX);
        expect_swap("gaps", 1'b1);

        // start while waiting for blanking is ignored
        run_frame("ignore", 1'b0, NPIX - 1, 10'd100, 1'b0, NPIX);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore.still_waiting", busy, 1);
        chk("ignore.no_ready", in_ready, 0);
        expect_swap("ignore", 1'b0);

        // in_last on beat 7 -> error, capture continues to 16 beats
        run_frame("frame_err", 1'b0, 6, 10'd450, 1'b1, NPIX);
        expect_swap("frame_err", 1'b1);
        chk("frame_err.error_sticky", error, 1);

        // Reset after beat 9, then a clean frame restarting at the base address
        run_frame("abort", 1'b0, NPIX - 1, 10'd100, 1'b0, 9);
        #5;
        rst_n = 1'b0;
        #1;
        chk("abort.wr_en", wr_en, 0);
        chk("abort.wr_address", wr_address, 0);
        chk("abort.in_ready", in_ready, 0);
        chk("abort.enter", enter, 0);
        chk("abort.busy", busy, 0);
        @(negedge clk_25);
        rst_n = 1'b1;
        tick();
        run_frame("restart", 1'b0, NPIX - 1, 10'd460, 1'b0, NPIX);
        expect_swap("restart", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
